// File: rtl/frame_config_sequencer_pkg.sv
// Shared definitions for the frame configuration sequencer: controller
// states, the default sync word, the header desync bit and the idle row index.
package frame_config_sequencer_pkg;

    typedef enum logic [2:0] {
        UNSYNCED,
        HEADER,
        DATA,
        FLUSH,
        STROBE
    } state_t;

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;
    localparam int          DESYNC_BIT        = 31;
    localparam int          ROW_IDLE          = 0;

endpackage

// File: rtl/frame_config_sequencer.sv
// Frame configuration sequencer: waits for a sync word, then parses frames of
// one header word plus NUMBER_OF_ROWS data words, drives each data word onto
// the shared FrameData/RowSelect bus and pulses FrameStrobe once per frame.
module frame_config_sequencer
    import frame_config_sequencer_pkg::*;
#(
    parameter int          FRAME_BITS_PER_ROW = 32,
    parameter int          ROW_SELECT_WIDTH   = 5,
    parameter int          NUMBER_OF_ROWS     = 16,
    parameter logic [31:0] SYNC_WORD          = DEFAULT_SYNC_WORD
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [FRAME_BITS_PER_ROW-1:0] Data_I,
    input  logic                          Valid_I,
    output logic                          Ready_O,
    output logic [FRAME_BITS_PER_ROW-1:0] FrameData_O,
    output logic [ROW_SELECT_WIDTH-1:0]   RowSelect_O,
    output logic [31:0]                   FrameAddress_O,
    output logic                          FrameStrobe_O,
    output logic                          Synced_O,
    output logic [15:0]                   FrameCount_O
);

    localparam logic [ROW_SELECT_WIDTH-1:0] LAST_ROW  = ROW_SELECT_WIDTH'(NUMBER_OF_ROWS);
    localparam logic [ROW_SELECT_WIDTH-1:0] FIRST_ROW = ROW_SELECT_WIDTH'(1);
    localparam logic [ROW_SELECT_WIDTH-1:0] IDLE_ROW  = ROW_SELECT_WIDTH'(ROW_IDLE);

    // The row counter must never wrap and the header/sync words are 32 bits,
    // so illegal parameter combinations are rejected at elaboration.
    if (NUMBER_OF_ROWS < 1 || NUMBER_OF_ROWS > (2 ** ROW_SELECT_WIDTH) - 1) begin : g_bad_rows
        $error("NUMBER_OF_ROWS out of range for ROW_SELECT_WIDTH");
    end
    if (FRAME_BITS_PER_ROW < 32) begin : g_bad_width
        $error("FRAME_BITS_PER_ROW must be at least 32");
    end

    state_t                      state;
    state_t                      state_next;
    logic                        accept;
    logic                        is_sync;
    logic                        is_desync;
    logic [ROW_SELECT_WIDTH-1:0] row_count;

    // Word-level decodes shared by the FSM and the datapath.
    always_comb begin
        Ready_O   = (state == UNSYNCED) || (state == HEADER) || (state == DATA);
        accept    = Valid_I && Ready_O;
        is_sync   = (Data_I[31:0] == SYNC_WORD);
        is_desync = Data_I[DESYNC_BIT];
    end

    // State register; reset always drops back to the unsynced state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= UNSYNCED;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: words only move the FSM when accepted, while FLUSH
    // and STROBE are fixed single-cycle steps of the frame commit.
    always_comb begin
        state_next = state;
        case (state)
            UNSYNCED: if (accept && is_sync)           state_next = HEADER;
            HEADER:   if (accept)                      state_next = is_desync ? UNSYNCED : DATA;
            DATA:     if (accept && row_count == LAST_ROW) state_next = FLUSH;
            FLUSH:                                     state_next = STROBE;
            STROBE:                                    state_next = HEADER;
            default:                                   state_next = UNSYNCED;
        endcase
    end

    // Registered outputs and row counter; the last row stays selected during
    // FLUSH so it latches, then the bus idles and the strobe fires for one cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            FrameData_O    <= '0;
            RowSelect_O    <= IDLE_ROW;
            FrameAddress_O <= '0;
            FrameStrobe_O  <= 1'b0;
            Synced_O       <= 1'b0;
            FrameCount_O   <= '0;
            row_count      <= '0;
        end else begin
            case (state)
                UNSYNCED: begin
                    if (accept && is_sync) begin
                        Synced_O <= 1'b1;
                    end
                end
                HEADER: begin
                    if (accept) begin
                        if (is_desync) begin
                            Synced_O <= 1'b0;
                        end else begin
                            FrameAddress_O <= Data_I[31:0];
                            row_count      <= FIRST_ROW;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        FrameData_O <= Data_I;
                        RowSelect_O <= row_count;
                        row_count   <= row_count + FIRST_ROW;
                    end
                end
                FLUSH: begin
                    RowSelect_O   <= IDLE_ROW;
                    FrameStrobe_O <= 1'b1;
                end
                STROBE: begin
                    FrameStrobe_O <= 1'b0;
                    FrameCount_O  <= FrameCount_O + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Self-checking bench for frame_config_sequencer: directed protocol steps on a
// 16-row instance, a randomized stream checked against a stream-parsing model,
// and a 1-row instance checked for its 4-cycle frame period.
module tb_frame_config_sequencer;

    localparam int          ROWS = 16;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [31:0] dataA  = '0;
    logic        validA = 1'b0;
    logic        readyA;
    logic [31:0] frameDataA;
    logic [4:0]  rowSelA;
    logic [31:0] frameAddrA;
    logic        strobeA;
    logic        syncedA;
    logic [15:0] countA;

    logic [31:0] dataB  = '0;
    logic        validB = 1'b0;
    logic        readyB;
    logic [31:0] frameDataB;
    logic [4:0]  rowSelB;
    logic [31:0] frameAddrB;
    logic        strobeB;
    logic        syncedB;
    logic [15:0] countB;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          wrRow[$];
    logic [31:0] wrData[$];
    logic [31:0] sbAddr[$];
    int          strobeDouble = 0;
    logic        prevStrobe   = 1'b0;
    logic [4:0]  prevRow      = '0;
    logic [31:0] prevData     = '0;

    frame_config_sequencer #(.NUMBER_OF_ROWS(ROWS)) dutA (
        .CLK(clock), .RESET(reset), .Data_I(dataA), .Valid_I(validA),
        .Ready_O(readyA), .FrameData_O(frameDataA), .RowSelect_O(rowSelA),
        .FrameAddress_O(frameAddrA), .FrameStrobe_O(strobeA),
        .Synced_O(syncedA), .FrameCount_O(countA)
    );

    frame_config_sequencer #(.NUMBER_OF_ROWS(1)) dutB (
        .CLK(clock), .RESET(reset), .Data_I(dataB), .Valid_I(validB),
        .Ready_O(readyB), .FrameData_O(frameDataB), .RowSelect_O(rowSelB),
        .FrameAddress_O(frameAddrB), .FrameStrobe_O(strobeB),
        .Synced_O(syncedB), .FrameCount_O(countB)
    );

    // Free-running clock and cycle counter.
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Hard stop in case the stimulus itself gets stuck.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Bus monitor for dutA: records each new row write and each strobe cycle.
    always @(posedge clock) begin
        #2;
        if (rowSelA != 5'd0 && (rowSelA != prevRow || frameDataA != prevData)) begin
            wrRow.push_back(int'(rowSelA));
            wrData.push_back(frameDataA);
        end
        if (strobeA) sbAddr.push_back(frameAddrA);
        if (strobeA && prevStrobe) strobeDouble++;
        prevStrobe = strobeA;
        prevRow    = rowSelA;
        prevData   = frameDataA;
    end

    // Counts one comparison and reports it if it does not hold.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one word on dutA and holds it until it is accepted.
    task automatic applyStimulus(input logic [31:0] w);
        int budget = 50;
        dataA  = w;
        validA = 1'b1;
        while (!readyA && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        if (budget == 0) checkOutput("ready_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        validA = 1'b0;
    endtask

    task automatic idle(input int n);
        validA = 1'b0;
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic clearMonitor();
        wrRow.delete();
        wrData.delete();
        sbAddr.delete();
        strobeDouble = 0;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic checkFrameWrites(input logic [31:0] base);
        checkOutput("frame_nwrites", wrRow.size(), ROWS);
        for (int i = 0; i < ROWS && i < wrRow.size(); i++) begin
            checkOutput("frame_row", wrRow[i], i + 1);
            checkOutput("frame_data", wrData[i], base + i);
        end
    endtask

    logic [31:0] stim[$];
    int          expRow[$];
    logic [31:0] expData[$];
    logic [31:0] expAddr[$];
    logic [31:0] streamB[$];
    int          nStrobeB   = 0;
    int          lastStrobe = 0;

    // 1-row instance: strobes must come every 4 cycles with the right address.
    task automatic checkStrobeB();
        if (strobeB) begin
            if (nStrobeB > 0) checkOutput("b_period", cyc - lastStrobe, 4);
            checkOutput("b_addr", frameAddrB, nStrobeB);
            lastStrobe = cyc;
            nStrobeB++;
        end
    endtask

    initial begin
        logic        synced;
        logic [31:0] addr;
        int          k;
        int          r;
        int          idx;
        int          cycles;
        logic        rd;

        // Reset state.
        @(posedge clock); #1;
        checkOutput("rst_rowsel", 32'(rowSelA), 0);
        checkOutput("rst_data", frameDataA, 0);
        checkOutput("rst_addr", frameAddrA, 0);
        checkOutput("rst_strobe", 32'(strobeA), 0);
        checkOutput("rst_synced", 32'(syncedA), 0);
        checkOutput("rst_count", 32'(countA), 0);
        checkOutput("rst_ready", 32'(readyA), 1);
        reset = 1'b0;
        clearMonitor();

        // Non-sync words while unsynced are dropped.
        $display("[TB] junk before sync");
        applyStimulus(32'h1234_5678);
        applyStimulus(32'h0000_0001);
        idle(2);
        checkOutput("junk_synced", 32'(syncedA), 0);
        checkOutput("junk_nwrites", wrRow.size(), 0);

        // First frame, continuous valid, with exact commit timing.
        $display("[TB] frame with continuous valid");
        applyStimulus(SYNC);
        checkOutput("sync_synced", 32'(syncedA), 1);
        applyStimulus(32'h0000_0305);
        checkOutput("hdr_addr", frameAddrA, 32'h0000_0305);
        for (int i = 0; i < ROWS; i++) applyStimulus(32'hA000_0000 + i);
        checkOutput("flush_rowsel", 32'(rowSelA), ROWS);
        checkOutput("flush_ready", 32'(readyA), 0);
        checkOutput("flush_strobe", 32'(strobeA), 0);
        dataA  = 32'h0000_0305;
        validA = 1'b1;
        @(posedge clock); #1;
        checkOutput("strobe_high", 32'(strobeA), 1);
        checkOutput("strobe_rowsel", 32'(rowSelA), 0);
        checkOutput("strobe_ready", 32'(readyA), 0);
        checkOutput("strobe_count", 32'(countA), 0);
        @(posedge clock); #1;
        checkOutput("post_strobe", 32'(strobeA), 0);
        checkOutput("post_count", 32'(countA), 1);
        checkOutput("post_ready", 32'(readyA), 1);
        checkFrameWrites(32'hA000_0000);
        checkOutput("f1_nstrobe", sbAddr.size(), 1);
        if (sbAddr.size() > 0) checkOutput("f1_strobe_addr", sbAddr[0], 32'h0000_0305);
        checkOutput("f1_strobe_width", strobeDouble, 0);

        // Second frame with valid toggling every cycle.
        $display("[TB] frame with toggled valid");
        clearMonitor();
        applyStimulus(32'h0000_0305);
        for (int i = 0; i < ROWS; i++) begin
            applyStimulus(32'hA000_0000 + i);
            idle(1);
        end
        idle(3);
        checkFrameWrites(32'hA000_0000);
        checkOutput("f2_nstrobe", sbAddr.size(), 1);
        checkOutput("f2_strobe_width", strobeDouble, 0);
        checkOutput("f2_count", 32'(countA), 2);

        // Header with bit 31 set desyncs; later words are ignored.
        $display("[TB] desync header");
        clearMonitor();
        applyStimulus(32'h8000_0000);
        checkOutput("desync_synced", 32'(syncedA), 0);
        checkOutput("desync_addr", frameAddrA, 32'h0000_0305);
        applyStimulus(32'h0000_0001);
        applyStimulus(32'h0000_0002);
        idle(4);
        checkOutput("desync_count", 32'(countA), 2);
        checkOutput("desync_nwrites", wrRow.size(), 0);
        checkOutput("desync_nstrobe", sbAddr.size(), 0);

        // Reset in the middle of a frame drops it without a strobe.
        $display("[TB] reset mid-frame");
        applyStimulus(SYNC);
        applyStimulus(32'h0000_0777);
        for (int i = 0; i < 7; i++) applyStimulus(32'hB000_0000 + i);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checkOutput("mid_rowsel", 32'(rowSelA), 0);
        checkOutput("mid_data", frameDataA, 0);
        checkOutput("mid_addr", frameAddrA, 0);
        checkOutput("mid_strobe", 32'(strobeA), 0);
        checkOutput("mid_synced", 32'(syncedA), 0);
        checkOutput("mid_count", 32'(countA), 0);
        idle(4);
        checkOutput("mid_nstrobe", sbAddr.size(), 0);
        clearMonitor();
        applyStimulus(32'h0000_0111);
        for (int i = 0; i < 3; i++) applyStimulus(32'hC000_0000 + i);
        idle(2);
        checkOutput("mid_nosync_nwrites", wrRow.size(), 0);
        checkOutput("mid_nosync_synced", 32'(syncedA), 0);

        // Randomized word stream checked against a stream-parsing model.
        $display("[TB] random stream");
        pulseReset();
        clearMonitor();
        for (int g = 0; g < 6; g++) begin
            repeat ($urandom_range(0, 2)) stim.push_back($urandom | 32'h0000_0001);
            stim.push_back(SYNC);
            repeat ($urandom_range(1, 3)) begin
                stim.push_back({1'b0, 31'($urandom)});
                repeat (ROWS) stim.push_back($urandom);
            end
            if ($urandom_range(0, 3) == 0) stim.push_back({1'b1, 31'($urandom)});
        end
        stim.push_back(SYNC);
        stim.push_back(32'h0000_0ABC);
        repeat ($urandom_range(1, ROWS - 1)) stim.push_back($urandom);

        synced = 1'b0;
        k = 0;
        while (k < stim.size()) begin
            if (!synced) begin
                if (stim[k] == SYNC) synced = 1'b1;
                k++;
            end else if (stim[k][31]) begin
                synced = 1'b0;
                k++;
            end else begin
                addr = stim[k];
                k++;
                r = 0;
                while (r < ROWS && k < stim.size()) begin
                    expRow.push_back(r + 1);
                    expData.push_back(stim[k]);
                    k++;
                    r++;
                end
                if (r == ROWS) expAddr.push_back(addr);
            end
        end

        foreach (stim[i]) begin
            applyStimulus(stim[i]);
            idle($urandom_range(0, 2));
        end
        idle(6);
        checkOutput("rand_nwrites", wrRow.size(), expRow.size());
        for (int i = 0; i < wrRow.size() && i < expRow.size(); i++) begin
            checkOutput("rand_row", wrRow[i], expRow[i]);
            checkOutput("rand_data", wrData[i], expData[i]);
        end
        checkOutput("rand_nstrobe", sbAddr.size(), expAddr.size());
        for (int i = 0; i < sbAddr.size() && i < expAddr.size(); i++) begin
            checkOutput("rand_strobe_addr", sbAddr[i], expAddr[i]);
        end
        checkOutput("rand_count", 32'(countA), expAddr.size());
        checkOutput("rand_synced", 32'(syncedA), 32'(synced));
        checkOutput("rand_strobe_width", strobeDouble, 0);

        // One-row instance with continuous valid: one frame every 4 cycles.
        $display("[TB] single-row instance");
        pulseReset();
        streamB.push_back(SYNC);
        for (int f = 0; f < 200; f++) begin
            streamB.push_back(32'(f));
            streamB.push_back($urandom);
        end
        idx    = 0;
        cycles = 0;
        while (idx < streamB.size() && cycles < 2000) begin
            validB = 1'b1;
            dataB  = streamB[idx];
            rd     = readyB;
            @(posedge clock); #1;
            cycles++;
            if (rd) idx++;
            checkStrobeB();
        end
        validB = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
            checkStrobeB();
        end
        checkOutput("b_consumed", idx, streamB.size());
        checkOutput("b_nstrobe", nStrobeB, 200);
        checkOutput("b_count", 32'(countB), 200);
        checkOutput("b_rowsel_idle", 32'(rowSelB), 0);
        checkOutput("b_last_data", frameDataB, streamB[streamB.size() - 1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
